// File: rtl/apb_bridge_pkg.sv
// ----------------------------------------------------------------------------
// apb_bridge_pkg
//   Shared definitions for the AHB-to-APB bridge controller (apb_master_ctrl).
//   - state_e     : FSM state encodings (4-bit)
//   - HRESP_*     : AHB response codes
//   - is_onehot() : legality check for the registered slave select
// ----------------------------------------------------------------------------
package apb_bridge_pkg;

  // Controller states. ERR1/ERR2 form the two-cycle AHB ERROR response.
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    READ    = 4'd1,  // APB setup phase, read
    WWAIT   = 4'd2,  // AHB write data phase, Hwdata captured here
    WRITE   = 4'd3,  // APB setup phase, write
    RENABLE = 4'd4,  // APB access phase, read
    WENABLE = 4'd5,  // APB access phase, write
    ERR1    = 4'd6,  // ERROR, Hreadyout low
    ERR2    = 4'd7   // ERROR, Hreadyout high
  } state_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // Widest slave-select vector the one-hot helper accepts.
  localparam int MAX_NSLV = 32;

  // True when exactly one bit of v is set (zero is not one-hot).
  function automatic logic is_onehot(input logic [MAX_NSLV-1:0] v);
    return (v != '0) && ((v & (v - MAX_NSLV'(1))) == '0);
  endfunction

endpackage

// File: rtl/apb_master_ctrl_if.sv
// ----------------------------------------------------------------------------
// apb_master_ctrl_if
//   Bus bundle between the AHB slave front end, the bridge controller and the
//   APB peripherals.
//   AHB side : valid, Hwrite, Haddr, tempselx, Hwdata  -> controller
//              Hreadyout, Hresp, Hrdata                -> AHB
//   APB side : Paddr, Pwdata, Pwrite, Pselx, Penable   -> peripherals
//              Prdata (slave i at [i*DW +: DW]), Pready, Pslverr -> controller
//   Modports : master (the bridge controller), slave (everything around it).
// ----------------------------------------------------------------------------
interface apb_master_ctrl_if #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int NSLV = 3
) ();

  // AHB address/data phase
  logic                valid;
  logic                Hwrite;
  logic [AW-1:0]       Haddr;
  logic [NSLV-1:0]     tempselx;
  logic [DW-1:0]       Hwdata;
  logic                Hreadyout;
  logic                Hresp;
  logic [DW-1:0]       Hrdata;

  // APB
  logic [AW-1:0]       Paddr;
  logic [DW-1:0]       Pwdata;
  logic                Pwrite;
  logic [NSLV-1:0]     Pselx;
  logic                Penable;
  logic [NSLV*DW-1:0]  Prdata;
  logic [NSLV-1:0]     Pready;
  logic [NSLV-1:0]     Pslverr;

  modport master (
    input  valid, Hwrite, Haddr, tempselx, Hwdata,
    input  Prdata, Pready, Pslverr,
    output Hreadyout, Hresp, Hrdata,
    output Paddr, Pwdata, Pwrite, Pselx, Penable
  );

  modport slave (
    output valid, Hwrite, Haddr, tempselx, Hwdata,
    output Prdata, Pready, Pslverr,
    input  Hreadyout, Hresp, Hrdata,
    input  Paddr, Pwdata, Pwrite, Pselx, Penable
  );

endinterface

// File: rtl/apb_rdata_mux.sv
// ----------------------------------------------------------------------------
// apb_rdata_mux
//   NSLV-way AND-OR selection of the per-slave APB return signals by the
//   registered one-hot slave select. A zero select yields all zeros.
//   Ports:
//     sel     in  NSLV     one-hot slave select
//     prdata  in  NSLV*DW  slave read data, slave i at [i*DW +: DW]
//     pready  in  NSLV     per-slave ready
//     pslverr in  NSLV     per-slave error
//     rdata   out DW       selected read data
//     ready   out 1        selected ready
//     slverr  out 1        selected error
// ----------------------------------------------------------------------------
module apb_rdata_mux #(
  parameter int DW   = 32,
  parameter int NSLV = 3
) (
  input  logic [NSLV-1:0]    sel,
  input  logic [NSLV*DW-1:0] prdata,
  input  logic [NSLV-1:0]    pready,
  input  logic [NSLV-1:0]    pslverr,
  output logic [DW-1:0]      rdata,
  output logic               ready,
  output logic               slverr
);

  // NOTE: every output of a combinational block gets a default before any
  // conditional update, otherwise synthesis infers a latch.
  always_comb begin
    rdata  = '0;
    ready  = 1'b0;
    slverr = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      rdata  = rdata | (prdata[i*DW +: DW] & {DW{sel[i]}});
      ready  = ready  | (pready[i]  & sel[i]);
      slverr = slverr | (pslverr[i] & sel[i]);
    end
  end

endmodule

// File: rtl/apb_master_ctrl.sv
// ----------------------------------------------------------------------------
// apb_master_ctrl
//   AHB-to-APB bridge control FSM with APB3 wait states (Pready), slave error
//   return (Pslverr -> two-cycle AHB ERROR) and an NSLV-way read-back mux.
//   Ports:
//     Hclk     in   clock, rising edge
//     Hresetn  in   asynchronous active-low reset
//     bus      apb_master_ctrl_if.master: AHB request/response and APB bus
//   Latency (address phase to Hreadyout=1): read 3, write 4, +1 per Pready=0.
//   Hreadyout/Hresp are combinational; all APB outputs and Hrdata are
//   registered. Hrdata is loaded on the edge that ends a successful read.
//   Optional feature, macro APB_TIMEOUT_EN: abort an access after TO_CYC
//   access cycles with Pready low and return ERROR. Without the macro the
//   access waits indefinitely and no counter exists.
// ----------------------------------------------------------------------------
module apb_master_ctrl
  import apb_bridge_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int NSLV   = 3,
  parameter int TO_CYC = 255
) (
  input  logic               Hclk,
  input  logic               Hresetn,
  apb_master_ctrl_if.master  bus
);

  state_e            state_q, state_d;

  // Address-phase capture
  logic [AW-1:0]     addr_q, addr_d;
  logic [NSLV-1:0]   sel_q, sel_d;
  logic              write_q, write_d;
  logic              capture;

  // Registered outputs
  logic [AW-1:0]     paddr_q;
  logic [DW-1:0]     pwdata_q;
  logic [DW-1:0]     hrdata_q;
  logic              pwrite_q;
  logic [NSLV-1:0]   pselx_q;
  logic              penable_q;

  // Combinational outputs
  logic              hreadyout;
  logic              hresp;

  // Selected slave response
  logic [DW-1:0]     mux_rdata;
  logic              mux_ready;
  logic              mux_slverr;

  logic              setup_d;   // next state is an APB setup phase
  logic              access_d;  // next state is an APB access phase
  logic              access_q;  // current state is an APB access phase
  logic              sel_ok_q;  // registered select is legal
  logic              timeout;   // access has waited too long

  apb_rdata_mux #(
    .DW   (DW),
    .NSLV (NSLV)
  ) u_rdata_mux (
    .sel     (sel_q),
    .prdata  (bus.Prdata),
    .pready  (bus.Pready),
    .pslverr (bus.Pslverr),
    .rdata   (mux_rdata),
    .ready   (mux_ready),
    .slverr  (mux_slverr)
  );

  // A new address phase is taken whenever the bridge shows ready.
  assign capture = bus.valid & hreadyout;
  assign addr_d  = capture ? bus.Haddr    : addr_q;
  assign sel_d   = capture ? bus.tempselx : sel_q;
  assign write_d = capture ? bus.Hwrite   : write_q;

  assign sel_ok_q = is_onehot(MAX_NSLV'(sel_q));
  assign access_q = (state_q == RENABLE) || (state_q == WENABLE);
  assign setup_d  = (state_d == READ)    || (state_d == WRITE);
  assign access_d = (state_d == RENABLE) || (state_d == WENABLE);

  // ---------------------------------------------------------------------------
  // Next state and AHB response
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    hreadyout = 1'b0;
    hresp     = HRESP_OKAY;
    unique case (state_q)
      IDLE: begin
        hreadyout = 1'b1;
        if (bus.valid) state_d = bus.Hwrite ? WWAIT : READ;
      end
      WWAIT: state_d = WRITE;
      READ:  state_d = sel_ok_q ? RENABLE : ERR1;
      WRITE: state_d = sel_ok_q ? WENABLE : ERR1;
      RENABLE, WENABLE: begin
        if (mux_ready) begin
          if (mux_slverr) begin
            state_d = ERR1;
          end else begin
            // Completion cycle doubles as the next address phase.
            hreadyout = 1'b1;
            if (bus.valid) state_d = bus.Hwrite ? WWAIT : READ;
            else           state_d = IDLE;
          end
        end else if (timeout) begin
          state_d = ERR1;
        end
      end
      ERR1: begin
        hresp   = HRESP_ERROR;
        state_d = ERR2;
      end
      ERR2: begin
        hresp     = HRESP_ERROR;
        hreadyout = 1'b1;
        if (bus.valid) state_d = bus.Hwrite ? WWAIT : READ;
        else           state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers. APB outputs are derived from the next state so
  // they are valid for the whole of the state they belong to.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      sel_q     <= '0;
      write_q   <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      hrdata_q  <= '0;
      pwrite_q  <= 1'b0;
      pselx_q   <= '0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      write_q   <= write_d;

      // An illegal select never reaches the APB bus.
      if ((setup_d || access_d) && is_onehot(MAX_NSLV'(sel_d))) pselx_q <= sel_d;
      else                                                       pselx_q <= '0;
      penable_q <= access_d;

      // Paddr/Pwrite change only on setup entry and hold otherwise.
      if (setup_d) begin
        paddr_q  <= addr_d;
        pwrite_q <= write_d;
      end

      if (state_q == WWAIT) pwdata_q <= bus.Hwdata;

      if ((state_q == RENABLE) && mux_ready && !mux_slverr) hrdata_q <= mux_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Access timeout
  // ---------------------------------------------------------------------------
`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = (TO_CYC < 2) ? 1 : $clog2(TO_CYC);

  logic [CNT_W-1:0] to_cnt_q;

  // to_cnt_q holds the number of earlier access cycles with Pready low, so
  // the TO_CYC-th such cycle is the one that aborts.
  assign timeout = access_q && (to_cnt_q == CNT_W'(TO_CYC - 1));

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      to_cnt_q <= '0;
    end else if (setup_d) begin
      to_cnt_q <= '0;
    end else if (access_q && !mux_ready && !timeout) begin
      to_cnt_q <= to_cnt_q + CNT_W'(1);
    end
  end
`else
  logic unused_to_cyc;

  assign timeout       = 1'b0;
  assign unused_to_cyc = (TO_CYC != 0) | access_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.Hreadyout = hreadyout;
  assign bus.Hresp     = hresp;
  assign bus.Hrdata    = hrdata_q;
  assign bus.Paddr     = paddr_q;
  assign bus.Pwdata    = pwdata_q;
  assign bus.Pwrite    = pwrite_q;
  assign bus.Pselx     = pselx_q;
  assign bus.Penable   = penable_q;

endmodule
